// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one INCR write (AW/W/B) or read (AR/R) burst at a time, fed from local command and beat streams.
// Optional watchdog enabled with `define AXI_MASTER_TIMEOUT_EN (limit TIMEOUT_CYC cycles, finishes with resp 2'b11).
module axi_burst_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                a_clk,
  input  logic                a_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic [1:0]          resp,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [LEN_W-1:0]    arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  output logic [2:0]          dbg_state
);

  // Handshakes: a beat or request transfers on the rising edge where valid and
  // ready are both high; valid never waits on ready and is held until accepted.
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [LEN_W:0]      cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          resp_q;
  logic                done_q, awvalid_q, arvalid_q, bready_q;
  logic                in_w, in_r, last_beat, hs;

  assign in_w      = (state_q == S_W);
  assign in_r      = (state_q == S_R);
  // Wide counter so a full-length burst never wraps before the last compare.
  assign last_beat = (cnt_q == {1'b0, len_q});

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign resp      = resp_q;
  assign dbg_state = state_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign bready  = bready_q;

  assign wvalid   = in_w & wr_valid;
  assign wdata    = in_w ? wr_data : '0;
  assign wstrb    = '1;
  assign wlast    = in_w & last_beat;
  assign wr_ready = in_w & wready;

  assign rready   = in_r & rd_ready;
  assign rd_valid = in_r & rvalid;
  assign rd_data  = in_r ? rdata : '0;
  assign rd_last  = in_r & rlast;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hs      = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        size_d  = cmd_size;
        cnt_d   = '0;
        err_d   = 2'b00;
        state_d = cmd_write ? S_AW : S_AR;
      end
      S_AW: if (awready) begin
        hs      = 1'b1;
        state_d = S_W;
      end
      S_W: if (wvalid && wready) begin
        hs    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = S_B;
      end
      S_B: if (bvalid) begin
        hs      = 1'b1;
        err_d   = bresp;
        state_d = S_DONE;
      end
      S_AR: if (arready) begin
        hs      = 1'b1;
        state_d = S_R;
      end
      S_R: if (rvalid && rready) begin
        hs    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (rresp != 2'b00) err_d = rresp;
        if (rlast != last_beat) err_d = 2'b10;
        // Exit is counted, so a misplaced rlast cannot cut the burst short.
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef AXI_MASTER_TIMEOUT_EN
    wd_d = '0;
    if (!hs && state_q != S_IDLE && state_q != S_DONE) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_DONE;
        err_d   = 2'b11;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 2'b00;
      resp_q    <= 2'b00;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= (state_d == S_DONE);
      awvalid_q <= (state_d == S_AW);
      arvalid_q <= (state_d == S_AR);
      bready_q  <= (state_d == S_B);
      if (state_d == S_DONE) resp_q <= err_d;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: vector table of bursts against a small AXI slave/RAM model, plus reset-abort and watchdog sequences.
`timescale 1ns/1ps
module tb_axi_burst_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        a_clk = 1'b0;
  logic        a_rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        done;
  logic [1:0]  resp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [2:0]  dbg_state;

  axi_burst_master #(.ADDR_W(32), .DATA_W(64), .LEN_W(4), .TIMEOUT_CYC(TO)) dut (
    .a_clk(a_clk), .a_rst_n(a_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .resp(resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 a_clk = ~a_clk;
  int cyc = 0;
  always @(posedge a_clk) cyc <= cyc + 1;

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    int          aw_wait;
    logic        gap;
    int          bad_rlast;
    int          rr_beat;
    logic [1:0]  rr_val;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
    int          exp_lat;
    logic        tmo;
  } vec_t;

  vec_t        vecs[11];
  logic [63:0] wdat[11][16];
  logic [63:0] smem[1024];
  logic [63:0] ref_mem[1024];
  logic [63:0] exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- slave / stream model state ----------------
  int          cur_v = 0;
  logic [31:0] cur_addr = '0;
  logic [3:0]  cur_len = '0;
  logic [2:0]  cur_size = '0;
  logic        wr_en = 1'b0, gap_c = 1'b0, tog = 1'b0;
  int          aw_wait_c = 0, bad_rlast_c = -1, rr_beat_c = -1;
  logic [1:0]  rr_val_c = '0, bresp_c = '0;
  int          aw_hold = 0, ar_hold = 0;
  logic        aw_done = 1'b0, b_taken = 1'b0, r_act = 1'b0;
  logic [31:0] aw_addr_s = '0, ar_addr_s = '0;
  int          w_beats = 0, w_idx = 0, r_idx = 0, rd_beats = 0;
  int          done_cnt = 0, done_cyc = 0;
  logic [1:0]  done_resp = '0;
  logic        done_prev = 1'b0;

  function automatic int midx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'h3FF);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    wr_en = 1'b0; aw_done = 1'b0; b_taken = 1'b0; r_act = 1'b0;
    w_beats = 0; w_idx = 0; r_idx = 0; rd_beats = 0;
    exp_q.delete();
  endtask

  // Loads one vector into the slave model and queues the beats it should see.
  task automatic start_vec(input int v);
    clear_model();
    cur_v = v; cur_addr = vecs[v].addr; cur_len = vecs[v].len; cur_size = vecs[v].size;
    aw_wait_c = vecs[v].aw_wait; gap_c = vecs[v].gap; bad_rlast_c = vecs[v].bad_rlast;
    rr_beat_c = vecs[v].rr_beat; rr_val_c = vecs[v].rr_val; bresp_c = vecs[v].bresp;
    wr_en = vecs[v].wr;
    if (!vecs[v].tmo) begin
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        if (vecs[v].wr) begin
          exp_q.push_back(wdat[v][i]);
          ref_mem[midx(vecs[v].addr, i)] = wdat[v][i];
        end else begin
          exp_q.push_back(ref_mem[midx(vecs[v].addr, i)]);
        end
      end
    end
  endtask

  // ---------------- slave, local streams and scoreboard ----------------
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    forever begin
      @(negedge a_clk);
      if (a_rst_n) begin
        if (awvalid) begin
          chk("awaddr_hold", awaddr, cur_addr);
          chk("awlen_hold", awlen, cur_len);
        end
        if (awvalid && awready) begin
          aw_done = 1'b1; aw_addr_s = awaddr;
          chk("awsize", awsize, cur_size);
          chk("awburst", awburst, 2'b01);
        end
        if (wvalid && wready) begin
          chk("w_after_aw", aw_done, 1'b1);
          chk("wlast", wlast, w_beats == int'(cur_len));
          chk("wstrb", wstrb, 8'hFF);
          if (exp_q.size() == 0) chk("wdata_extra", 1'b1, 1'b0);
          else chk("wdata", wdata, exp_q.pop_front());
          smem[midx(aw_addr_s, w_beats)] = wdata;
          w_beats++;
        end
        if (wr_valid && wr_ready) w_idx++;
        if (bvalid && bready) b_taken = 1'b1;
        if (arvalid) begin
          chk("araddr_hold", araddr, cur_addr);
          chk("arlen_hold", arlen, cur_len);
        end
        if (arvalid && arready) begin
          r_act = 1'b1; ar_addr_s = araddr;
          chk("arsize", arsize, cur_size);
          chk("arburst", arburst, 2'b01);
        end
        if (rd_valid && rd_ready) begin
          chk("rd_last", rd_last, (bad_rlast_c >= 0) ? (r_idx == bad_rlast_c) : (r_idx == int'(cur_len)));
          if (exp_q.size() == 0) chk("rd_extra", 1'b1, 1'b0);
          else chk("rd_data", rd_data, exp_q.pop_front());
          rd_beats++;
        end
        if (rvalid && rready) r_idx++;
        if (done) begin
          chk("done_pulse", done_prev, 1'b0);
          chk("cmd_ready_in_done", cmd_ready, 1'b0);
          done_cnt++; done_resp = resp; done_cyc = cyc;
        end
        done_prev = done;
      end
      @(posedge a_clk);
      #1;
      if (awvalid) begin awready = (aw_hold >= aw_wait_c); aw_hold++; end
      else begin awready = 1'b0; aw_hold = 0; end
      if (arvalid) begin arready = (ar_hold >= aw_wait_c); ar_hold++; end
      else begin arready = 1'b0; ar_hold = 0; end
      wready = 1'b1;
      if (wr_en && w_idx <= int'(cur_len) && (!gap_c || $urandom_range(0, 1) == 1)) begin
        wr_valid = 1'b1; wr_data = wdat[cur_v][w_idx];
      end else begin
        wr_valid = 1'b0; wr_data = '0;
      end
      bvalid = wr_en && (w_beats == int'(cur_len) + 1) && !b_taken;
      bresp  = bresp_c;
      rvalid = r_act && (r_idx <= int'(cur_len));
      rdata  = rvalid ? smem[midx(ar_addr_s, r_idx)] : '0;
      rlast  = rvalid && ((bad_rlast_c >= 0) ? (r_idx == bad_rlast_c) : (r_idx == int'(cur_len)));
      rresp  = (rvalid && r_idx == rr_beat_c) ? rr_val_c : 2'b00;
      rd_ready = gap_c ? tog : 1'b1;
      tog = ~tog;
    end
  end

  // ---------------- command driver tasks ----------------
  task automatic issue_cmd(input int v, output int t0);
    @(posedge a_clk); #1;
    cmd_valid = 1'b1; cmd_write = vecs[v].wr; cmd_addr = vecs[v].addr;
    cmd_len = vecs[v].len; cmd_size = vecs[v].size;
    t0 = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge a_clk);
      if (cmd_ready) begin t0 = cyc; break; end
    end
    chk($sformatf("cmd_accept_v%0d", v), t0 >= 0, 1'b1);
    @(posedge a_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int t0, d0;
    start_vec(v);
    d0 = done_cnt;
    issue_cmd(v, t0);
    for (int k = 0; k < 500; k++) begin
      if (done_cnt != d0) break;
      @(negedge a_clk);
    end
    chk($sformatf("done_count_v%0d", v), done_cnt - d0, 1);
    chk($sformatf("resp_v%0d", v), done_resp, vecs[v].exp_resp);
    if (vecs[v].exp_lat >= 0) chk($sformatf("latency_v%0d", v), done_cyc - t0, vecs[v].exp_lat);
    if (!vecs[v].tmo) begin
      if (vecs[v].wr) begin
        chk($sformatf("w_beats_v%0d", v), w_beats, int'(vecs[v].len) + 1);
        for (int i = 0; i <= int'(vecs[v].len); i++)
          chk($sformatf("ram_v%0d_%0d", v, i), smem[midx(vecs[v].addr, i)], wdat[v][i]);
      end else begin
        chk($sformatf("rd_beats_v%0d", v), rd_beats, int'(vecs[v].len) + 1);
      end
      chk($sformatf("exp_q_empty_v%0d", v), exp_q.size(), 0);
    end else begin
      chk("awvalid_dropped", awvalid, 1'b0);
    end
    @(negedge a_clk);
    chk($sformatf("idle_after_v%0d", v), cmd_ready, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    a_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    for (int i = 0; i < 1024; i++) begin
      smem[i] = {32'hC0DE_0000, 32'(i)};
      ref_mem[i] = smem[i];
    end
    for (int i = 1; i <= 3; i++) begin smem[i] = 64'(i); ref_mem[i] = 64'(i); end
    for (int v = 0; v < 11; v++)
      for (int i = 0; i < 16; i++) wdat[v][i] = {16'hA5A5, 8'(v), 40'(i * 3 + 1)};
    wdat[0][0] = 64'hABCD; wdat[0][1] = 64'hFDDF; wdat[0][2] = 64'hFAFA;
    wdat[5][0] = 64'h55;   wdat[9][0] = 64'h77;
    //          wr    addr        len   size  aw_w gap   rlst rr_b rr_v   bresp  exp    lat tmo
    vecs[0]  = '{1'b1, 32'h0000_000A, 4'd2,  3'd1, 2,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00, -1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_2001, 4'd2,  3'd3, 0,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00,  5, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 4'd3,  3'd3, 1,    1'b1, -1, -1, 2'b00, 2'b01, 2'b01, -1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 4'd3,  3'd3, 0,    1'b1, -1, -1, 2'b00, 2'b00, 2'b00, -1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_2001, 4'd2,  3'd3, 0,    1'b0,  1, -1, 2'b00, 2'b00, 2'b10, -1, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0007, 4'd0,  3'd3, 0,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00,  4, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0007, 4'd0,  3'd3, 0,    1'b0, -1,  0, 2'b11, 2'b00, 2'b11, -1, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0100, 4'd15, 3'd3, 1,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00, -1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0060, 4'd2,  3'd3, 0,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00, -1, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0070, 4'd0,  3'd3, 0,    1'b0, -1, -1, 2'b00, 2'b00, 2'b00,  4, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0080, 4'd0,  3'd3, 1000, 1'b0, -1, -1, 2'b00, 2'b00, 2'b11, TO + 1, 1'b1};

    repeat (3) @(posedge a_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_resp", resp, 2'b00);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_awlen", awlen, 4'h0);
    chk("rst_state", dbg_state, 3'd0);
    a_rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(v);

    // Reset asserted in the middle of a write burst, then a fresh single-beat write.
    begin
      int t0;
      start_vec(8);
      d0 = done_cnt;
      issue_cmd(8, t0);
      for (int k = 0; k < 50; k++) begin
        if (w_beats >= 1) break;
        @(negedge a_clk);
      end
      chk("abort_reached_beat1", w_beats, 1);
      @(posedge a_clk); #1;
      a_rst_n = 1'b0;
      #1;
      chk("abort_wvalid", wvalid, 1'b0);
      chk("abort_wlast", wlast, 1'b0);
      chk("abort_wr_ready", wr_ready, 1'b0);
      chk("abort_awvalid", awvalid, 1'b0);
      chk("abort_bready", bready, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_awaddr", awaddr, 32'h0);
      chk("abort_state", dbg_state, 3'd0);
      clear_model();
      repeat (2) @(posedge a_clk);
      #1;
      a_rst_n = 1'b1;
      chk("abort_no_done", done_cnt - d0, 0);
      run_vec(9);
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    run_vec(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
